opn_reg_writer: RTL and testbench
=================================

Name: opn_reg_writer

Overview:
- Buffered register-write engine that sits directly upstream of the jt12 `top` CPU bus (`din`/`addr`/`cs_n`/`wr_n`).
- Accepts (register, value) pairs over a valid/ready handshake and queues them in a small FIFO.
- Replays each pair as the two-phase OPN bus write: address phase, then data phase.
- Enforces a programmable inter-write gap and, optionally, waits for the core's busy flag (`dout[7]`) to clear.
- Replaces hand-timed counter-compare write sequences in test harnesses and player logic.

Parameters:
- FIFO_DEPTH, 8, number of queued writes; power of two, minimum 2.
- GAP_CYCLES, 478, idle clk_in cycles inserted after each completed write; 0 means no gap.
- USE_BUSY, 1, when 1, wait for dout_in[7]==0 before every address phase.
- BUSY_TIMEOUT, 4096, maximum cycles spent waiting on busy before proceeding anyway.

Ports:
- clk_in, input, 1, single clock, the same 4 MHz domain that drives the core.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, 1, write request present.
- req_ready, output, 1, FIFO can accept a request this cycle.
- req_addr, input, 8, OPN register number.
- req_data, input, 8, value to write.
- dout_in, input, 8, core status byte; bit 7 is busy.
- din, output, 8, bus data to the core.
- addr, output, 1, 0 = address phase, 1 = data phase.
- cs_n, output, 1, chip select, active low.
- wr_n, output, 1, write strobe, active low.
- active, output, 1, high whenever the FSM is not in IDLE or the FIFO is non-empty.
- fifo_count, output, clog2(FIFO_DEPTH)+1, number of queued entries.
- done_pulse, output, 1, one-cycle pulse at the end of each data phase.
- busy_timeout, output, 1, sticky flag; set when a busy wait times out.

Behaviour:
- Reset (async, rst=1): FIFO emptied and state=IDLE. Outputs: din=0, addr=0, cs_n=1, wr_n=1, done_pulse=0, busy_timeout=0, fifo_count=0, req_ready=0. req_ready becomes 1 on the first clock after rst deasserts.
- Reset mid-write abandons the transfer immediately and drives the bus to the idle values above.
- Handshake: a push occurs on a rising edge where req_valid && req_ready.
- req_ready = !full, from the registered count. While full, req_ready=0; push and pop can never collide on a full FIFO.
- A push and a pop in the same cycle leave the count unchanged.
- FIFO ordering is first-in first-out. Pointers wrap modulo FIFO_DEPTH.
- All bus outputs are registered and decoded from the state.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop the head into hold_addr/hold_data, then go to BWAIT if USE_BUSY, else A_WR.
  - BWAIT: cs_n=1, wr_n=1. Leave to A_WR when dout_in[7]==0. After BUSY_TIMEOUT cycles, set busy_timeout and go to A_WR.
  - A_WR: cs_n=0, addr=0, din=hold_addr, wr_n=0. Lasts 1 cycle, then A_REL.
  - A_REL: cs_n=0, addr=0, wr_n=1, din held. Lasts 1 cycle, then D_WR.
  - D_WR: cs_n=0, addr=1, din=hold_data, wr_n=0. Lasts 1 cycle, then D_REL.
  - D_REL: cs_n=0, addr=0, wr_n=1, done_pulse=1. Lasts 1 cycle, then GAP if GAP_CYCLES>0, else IDLE.
  - GAP: cs_n=1, wr_n=1. Stays exactly GAP_CYCLES cycles (16-bit down-counter loaded on entry), then IDLE.
- Latency: with USE_BUSY=0 and an empty idle engine, a request pushed at edge t produces wr_n=0 (A_WR) during the cycle after edge t+2.
- Each write occupies 4 bus cycles plus GAP_CYCLES plus 1 IDLE cycle.
- Back-to-back queued writes therefore have a fixed period of 5+GAP_CYCLES cycles when not busy-stalled.
- Outside A_WR..D_REL: cs_n=1, wr_n=1, addr=0, and din holds its last value.
- wr_n is never low for two consecutive cycles.
- addr changes only while wr_n=1, or on the same edge as the wr_n falling edge.
- busy_timeout is cleared only by rst.
- active is 0 only when state=IDLE and fifo_count=0.

Test Plan:
- Reset release, single push of (0x27, 0x3B) with USE_BUSY=0 → two cycles later, A_WR shows din=0x27/addr=0/wr_n=0. Then A_REL, then D_WR shows din=0x3B/addr=1/wr_n=0. done_pulse is seen once, and active drops after GAP_CYCLES+1 cycles.
- Push 8 writes (0x07/0x38, 0xB0/0x07, 0x30/0x01, 0x40/0x00, 0x50/0x1F, 0xA4/0x24, 0xA0/0x0F, 0x28/0x10) → req_ready drops at count=8. The bus shows all pairs in order, with address-phase starts spaced exactly 483 cycles apart (GAP_CYCLES=478).
- Hold req_valid high while the engine pops → a simultaneous push/pop keeps fifo_count constant, and no entry is lost or duplicated.
- USE_BUSY=1, dout_in[7]=1 for 50 cycles → the engine stays in BWAIT with cs_n=1, and A_WR starts the cycle after bit 7 falls. With bit 7 held high, A_WR starts after 4096 cycles and busy_timeout=1.
- Assert rst during D_WR → the bus returns at once to cs_n=1/wr_n=1/addr=0/din=0, fifo_count=0, and no done_pulse is issued.

Source files
------------

// File: rtl/opn_reg_writer.sv
// Queued register-write engine for the jt12 CPU bus: buffers (register, value)
// pairs and replays each as an address phase followed by a data phase.
module opn_reg_writer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int GAP_CYCLES   = 478,
  parameter int USE_BUSY     = 1,
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic                        clk_in,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [7:0]                  req_addr,
  input  logic [7:0]                  req_data,
  input  logic [7:0]                  dout_in,
  output logic [7:0]                  din,
  output logic                        addr,
  output logic                        cs_n,
  output logic                        wr_n,
  output logic                        active,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        done_pulse,
  output logic                        busy_timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [15:0]   GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BWAIT = 3'd1,
    A_WR  = 3'd2,
    A_REL = 3'd3,
    D_WR  = 3'd4,
    D_REL = 3'd5,
    GAP   = 3'd6
  } state_t;

  state_t          state;
  logic [7:0]      q_addr [FIFO_DEPTH];
  logic [7:0]      q_data [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            rdy_en;
  logic [7:0]      hold_addr;
  logic [7:0]      hold_data;
  logic [15:0]     gap_cnt;
  logic [TW-1:0]   bw_cnt;
  logic            full;
  logic            push;
  logic            pop;

  // req_ready stays low through reset and comes up on the first clock after it.
  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign req_ready = rdy_en && !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0);
  assign active    = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      q_addr[wr_ptr] <= req_addr;
      q_data[wr_ptr] <= req_data;
    end
    if (pop) begin
      hold_addr <= q_addr[rd_ptr];
      hold_data <= q_data[rd_ptr];
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      bw_cnt       <= '0;
      busy_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state  <= (USE_BUSY != 0) ? BWAIT : A_WR;
            bw_cnt <= '0;
          end
        end
        BWAIT: begin
          // A clear busy bit wins over a timeout landing on the same cycle.
          if (!dout_in[7]) begin
            state <= A_WR;
          end else if (bw_cnt == TO_LAST) begin
            busy_timeout <= 1'b1;
            state        <= A_WR;
          end else begin
            bw_cnt <= bw_cnt + TW'(1);
          end
        end
        A_WR:  state <= A_REL;
        A_REL: state <= D_WR;
        D_WR:  state <= D_REL;
        D_REL: begin
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) state <= IDLE;
          else                  gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus pins are a registered decode of the state, one cycle behind it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      din        <= 8'h00;
      addr       <= 1'b0;
      cs_n       <= 1'b1;
      wr_n       <= 1'b1;
      done_pulse <= 1'b0;
    end else begin
      addr       <= 1'b0;
      cs_n       <= 1'b1;
      wr_n       <= 1'b1;
      done_pulse <= 1'b0;
      case (state)
        A_WR: begin
          cs_n <= 1'b0;
          wr_n <= 1'b0;
          din  <= hold_addr;
        end
        A_REL: cs_n <= 1'b0;
        D_WR: begin
          cs_n <= 1'b0;
          wr_n <= 1'b0;
          addr <= 1'b1;
          din  <= hold_data;
        end
        D_REL: begin
          cs_n       <= 1'b0;
          done_pulse <= 1'b1;
        end
        default: din <= din;
      endcase
    end
  end

endmodule

// File: tb/tb_opn_reg_writer.sv
// Bench for opn_reg_writer: one instance without busy polling (long gap) and
// one with busy polling (short gap); bus writes are checked against queues.
module tb_opn_reg_writer;
  logic       clk;
  logic       rst;
  logic       req_valid0, req_ready0, req_valid1, req_ready1;
  logic [7:0] req_addr0, req_data0, req_addr1, req_data1;
  logic [7:0] dout_in0, dout_in1, din0, din1;
  logic       addr0, cs_n0, wr_n0, active0, done_pulse0, busy_timeout0;
  logic       addr1, cs_n1, wr_n1, active1, done_pulse1, busy_timeout1;
  logic [3:0] fifo_count0, fifo_count1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int done_cnt0 = 0;
  int k, d0, bad;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          starts0[$];
  logic [7:0]  cur_a0, cur_a1;
  logic        prev_wr0 = 1'b1;
  logic        prev_wr1 = 1'b1;
  logic [15:0] e0, e1;
  logic [15:0] burst [8];
  int          fc_exp [4];

  opn_reg_writer #(.FIFO_DEPTH(8), .GAP_CYCLES(478), .USE_BUSY(0), .BUSY_TIMEOUT(4096)) u0 (
    .clk_in(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_addr(req_addr0), .req_data(req_data0), .dout_in(dout_in0), .din(din0),
    .addr(addr0), .cs_n(cs_n0), .wr_n(wr_n0), .active(active0),
    .fifo_count(fifo_count0), .done_pulse(done_pulse0), .busy_timeout(busy_timeout0));

  opn_reg_writer #(.FIFO_DEPTH(8), .GAP_CYCLES(4), .USE_BUSY(1), .BUSY_TIMEOUT(4096)) u1 (
    .clk_in(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_addr(req_addr1), .req_data(req_data1), .dout_in(dout_in1), .din(din1),
    .addr(addr1), .cs_n(cs_n1), .wr_n(wr_n1), .active(active1),
    .fifo_count(fifo_count1), .done_pulse(done_pulse1), .busy_timeout(busy_timeout1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for u0: pairs each address phase with the following data phase.
  always @(negedge clk) begin
    if (done_pulse0) done_cnt0++;
    if (!wr_n0) begin
      check("wr_n0_single_cycle", 32'(prev_wr0), 32'd1);
      if (!addr0) begin
        cur_a0 = din0;
        starts0.push_back(cyc);
      end else if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_write0: got %h/%h expected none", cur_a0, din0);
      end else begin
        e0 = q0.pop_front();
        check("bus_write0", 32'({cur_a0, din0}), 32'(e0));
      end
    end
    prev_wr0 = wr_n0;
  end

  always @(negedge clk) begin
    if (!wr_n1) begin
      check("wr_n1_single_cycle", 32'(prev_wr1), 32'd1);
      if (!addr1) begin
        cur_a1 = din1;
      end else if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_write1: got %h/%h expected none", cur_a1, din1);
      end else begin
        e1 = q1.pop_front();
        check("bus_write1", 32'({cur_a1, din1}), 32'(e1));
      end
    end
    prev_wr1 = wr_n1;
  end

  task automatic push0(input logic [7:0] a, input logic [7:0] d, input bit track);
    int n = 0;
    @(negedge clk);
    req_valid0 = 1'b1; req_addr0 = a; req_data0 = d;
    while (!req_ready0 && n < 10000) begin @(negedge clk); n++; end
    if (!req_ready0) begin
      tests++; fails++;
      $display("FAIL push0_timeout: ready=0 expected 1");
    end else if (track) q0.push_back({a, d});
  endtask

  task automatic push1(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req_valid1 = 1'b1; req_addr1 = a; req_data1 = d;
    while (!req_ready1 && n < 10000) begin @(negedge clk); n++; end
    if (!req_ready1) begin
      tests++; fails++;
      $display("FAIL push1_timeout: ready=0 expected 1");
    end else q1.push_back({a, d});
  endtask

  task automatic wait_idle0(input int bound);
    int n = 0;
    while (active0 && n < bound) begin @(negedge clk); n++; end
    check("idle0_reached", 32'(active0), 32'd0);
  endtask

  task automatic wait_idle1(input int bound);
    int n = 0;
    while (active1 && n < bound) begin @(negedge clk); n++; end
    check("idle1_reached", 32'(active1), 32'd0);
  endtask

  initial begin
    burst = '{16'h0738, 16'hB007, 16'h3001, 16'h4000,
              16'h501F, 16'hA424, 16'hA00F, 16'h2810};
    fc_exp = '{1, 1, 2, 3};
    rst = 1'b1;
    req_valid0 = 1'b0; req_addr0 = 8'h00; req_data0 = 8'h00; dout_in0 = 8'h00;
    req_valid1 = 1'b0; req_addr1 = 8'h00; req_data1 = 8'h00; dout_in1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_din",      32'(din0), 32'h00);
    check("rst_addr",     32'(addr0), 32'd0);
    check("rst_cs_n",     32'(cs_n0), 32'd1);
    check("rst_wr_n",     32'(wr_n0), 32'd1);
    check("rst_done",     32'(done_pulse0), 32'd0);
    check("rst_btimeout", 32'(busy_timeout0), 32'd0);
    check("rst_count",    32'(fifo_count0), 32'd0);
    check("rst_ready",    32'(req_ready0), 32'd0);
    check("rst_active",   32'(active0), 32'd0);
    check("rst_cs_n1",    32'(cs_n1), 32'd1);
    rst = 1'b0;
    check("ready_before_clk", 32'(req_ready0), 32'd0);
    @(negedge clk);
    check("ready_after_rel0", 32'(req_ready0), 32'd1);
    check("ready_after_rel1", 32'(req_ready1), 32'd1);

    // Single write, cycle-exact bus phases.
    push0(8'h27, 8'h3B, 1'b1);
    @(negedge clk); req_valid0 = 1'b0; k = 0; d0 = done_cnt0;
    check("t1_count_k0", 32'(fifo_count0), 32'd1);
    @(negedge clk); k++;
    check("t1_count_k1", 32'(fifo_count0), 32'd0);
    check("t1_wr_n_k1",  32'(wr_n0), 32'd1);
    @(negedge clk); k++;
    check("t1_awr", 32'({din0, addr0, wr_n0, cs_n0}), 32'({8'h27, 3'b000}));
    @(negedge clk); k++;
    check("t1_arel", 32'({din0, addr0, wr_n0, cs_n0}), 32'({8'h27, 3'b010}));
    @(negedge clk); k++;
    check("t1_dwr", 32'({din0, addr0, wr_n0, cs_n0}), 32'({8'h3B, 3'b100}));
    @(negedge clk); k++;
    check("t1_drel", 32'({done_pulse0, addr0, wr_n0, cs_n0}), 32'(4'b1010));
    @(negedge clk); k++;
    check("t1_after", 32'({done_pulse0, cs_n0, din0}), 32'({2'b01, 8'h3B}));
    while (active0 && k < 1000) begin @(negedge clk); k++; end
    check("t1_active_drop_cycle", 32'(k), 32'd483);
    check("t1_done_once", 32'(done_cnt0 - d0), 32'd1);

    // Lead-in write then eight queued writes filling the FIFO.
    starts0.delete();
    push0(8'h22, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) push0(burst[i][15:8], burst[i][7:0], 1'b1);
    @(negedge clk); req_valid0 = 1'b0;
    check("t2_count_full", 32'(fifo_count0), 32'd8);
    check("t2_ready_full", 32'(req_ready0), 32'd0);
    wait_idle0(6000);
    check("t2_nstarts", 32'(starts0.size()), 32'd9);
    for (int i = 1; i < 9 && i < starts0.size(); i++)
      check("t2_period", 32'(starts0[i] - starts0[i-1]), 32'd483);

    // Continuous valid on u1: push and pop share an edge.
    @(negedge clk);
    req_valid1 = 1'b1; {req_addr1, req_data1} = burst[0];
    check("t3_ready0", 32'(req_ready1), 32'd1);
    q1.push_back(burst[0]);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("t3_flow_count", 32'(fifo_count1), 32'(fc_exp[i-1]));
      check("t3_ready", 32'(req_ready1), 32'd1);
      {req_addr1, req_data1} = burst[i];
      q1.push_back(burst[i]);
    end
    @(negedge clk);
    check("t3_flow_count", 32'(fifo_count1), 32'(fc_exp[3]));
    req_valid1 = 1'b0;
    wait_idle1(500);

    // Busy held for 50 cycles, then released.
    dout_in1 = 8'h80;
    push1(8'h2A, 8'h80);
    @(negedge clk); req_valid1 = 1'b0; k = 0; bad = 0;
    repeat (50) begin
      @(negedge clk); k++;
      if (!cs_n1) bad++;
    end
    check("t4_bwait_cs_high", 32'(bad), 32'd0);
    dout_in1 = 8'h00;
    @(negedge clk);
    check("t4_wr_n_k51", 32'(wr_n1), 32'd1);
    @(negedge clk);
    check("t4_awr_k52", 32'({din1, addr1, wr_n1}), 32'({8'h2A, 2'b00}));
    check("t4_no_timeout", 32'(busy_timeout1), 32'd0);
    wait_idle1(500);

    // Busy stuck high: proceed after the timeout and flag it.
    dout_in1 = 8'h80;
    push1(8'h2B, 8'h81);
    @(negedge clk); req_valid1 = 1'b0; k = 0;
    while (wr_n1 && k < 5000) begin @(negedge clk); k++; end
    check("t4_timeout_cycle", 32'(k), 32'd4098);
    check("t4_timeout_flag", 32'(busy_timeout1), 32'd1);
    dout_in1 = 8'h00;
    wait_idle1(500);
    check("t4_timeout_sticky", 32'(busy_timeout1), 32'd1);

    // Reset in the middle of a data phase.
    push0(8'hB4, 8'hC0, 1'b1);
    push0(8'hB5, 8'h01, 1'b0);
    push0(8'hB6, 8'h02, 1'b0);
    @(negedge clk); req_valid0 = 1'b0; k = 0;
    while (!(!wr_n0 && addr0) && k < 20) begin @(negedge clk); k++; end
    check("t5_dwr_seen", 32'({wr_n0, addr0}), 32'(2'b01));
    d0 = done_cnt0;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_bus", 32'({din0, addr0, wr_n0, cs_n0}), 32'({8'h00, 3'b011}));
    check("t5_rst_count", 32'(fifo_count0), 32'd0);
    check("t5_rst_done", 32'(done_pulse0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_done", 32'(done_cnt0 - d0), 32'd0);
    check("t5_idle_after", 32'({active0, fifo_count0}), 32'd0);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
